// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: hunts a preamble, reads a frame count, then
// deserialises parity/stop-checked frames into per-CLB configuration writes.
module clb_cfg_loader #(
  parameter int unsigned CFG_W    = 37,
  parameter int unsigned ADDR_W   = 6,
  parameter logic [3:0]  PREAMBLE = 4'b0010
) (
  input  logic              K,
  input  logic              RST_N,
  input  logic              DIN,
  input  logic              DIN_EN,
  output logic [CFG_W-1:0]  CFG_DATA,
  output logic [ADDR_W-1:0] CFG_ADDR,
  output logic              CFG_WE,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned     MaxCnt    = (CFG_W > ADDR_W) ? CFG_W : ADDR_W;
  localparam int unsigned     CntW      = $clog2(MaxCnt);
  localparam logic [CntW-1:0] LastData  = CntW'(CFG_W - 1);
  localparam logic [CntW-1:0] LastCount = CntW'(ADDR_W - 1);

  typedef enum logic [2:0] {
    StHunt,
    StCount,
    StData,
    StPar,
    StStop,
    StDone,
    StErr
  } state_e;

  state_e              r_state, w_state_d;
  logic [3:0]          r_win, w_win_d;
  logic [ADDR_W-1:0]   r_n, w_n_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [CFG_W-1:0]    r_sr, w_sr_d;
  logic [ADDR_W-1:0]   r_idx, w_idx_d;
  logic                r_par_bad, w_par_bad_d;
  logic [CFG_W-1:0]    r_cfg_data, w_cfg_data_d;
  logic [ADDR_W-1:0]   r_cfg_addr, w_cfg_addr_d;
  logic                r_we, w_we_d;
  logic                r_done, w_done_d;
  logic                r_err, w_err_d;
  logic [ADDR_W-1:0]   w_idx_inc;

  assign w_idx_inc = r_idx + 1'b1;

  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= StHunt;
      r_win      <= '0;
      r_n        <= '0;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_idx      <= '0;
      r_par_bad  <= 1'b0;
      r_cfg_data <= '0;
      r_cfg_addr <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_win      <= w_win_d;
      r_n        <= w_n_d;
      r_cnt      <= w_cnt_d;
      r_sr       <= w_sr_d;
      r_idx      <= w_idx_d;
      r_par_bad  <= w_par_bad_d;
      r_cfg_data <= w_cfg_data_d;
      r_cfg_addr <= w_cfg_addr_d;
      r_we       <= w_we_d;
      r_done     <= w_done_d;
      r_err      <= w_err_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_win_d      = r_win;
    w_n_d        = r_n;
    w_cnt_d      = r_cnt;
    w_sr_d       = r_sr;
    w_idx_d      = r_idx;
    w_par_bad_d  = r_par_bad;
    w_cfg_data_d = r_cfg_data;
    w_cfg_addr_d = r_cfg_addr;
    w_we_d       = 1'b0;
    // DONE is registered off the state so it trails the final write strobe.
    w_done_d     = r_done | (r_state == StDone);
    w_err_d      = r_err;

    case (r_state)
      StHunt: begin
        if (DIN_EN) begin
          w_win_d = {r_win[2:0], DIN};
          if (w_win_d == PREAMBLE) begin
            w_state_d = StCount;
            w_cnt_d   = '0;
          end
        end
      end

      StCount: begin
        if (DIN_EN) begin
          w_n_d = {r_n[ADDR_W-2:0], DIN};
          if (r_cnt == LastCount) begin
            w_cnt_d = '0;
            w_idx_d = '0;
            w_state_d = (w_n_d == '0) ? StDone : StData;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end

      StData: begin
        if (DIN_EN) begin
          w_sr_d = {r_sr[CFG_W-2:0], DIN};
          if (r_cnt == LastData) begin
            w_cnt_d   = '0;
            w_state_d = StPar;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end

      StPar: begin
        if (DIN_EN) begin
          w_par_bad_d = DIN ^ (^r_sr);
          w_state_d   = StStop;
        end
      end

      StStop: begin
        if (DIN_EN) begin
          if (DIN && !r_par_bad) begin
            w_cfg_data_d = r_sr;
            w_cfg_addr_d = r_idx;
            w_we_d       = 1'b1;
            w_idx_d      = w_idx_inc;
            w_state_d    = (w_idx_inc == r_n) ? StDone : StData;
          end else begin
            w_err_d   = 1'b1;
            w_state_d = StErr;
          end
        end
      end

      StDone: w_state_d = StDone;
      StErr:  w_state_d = StErr;
      default: w_state_d = StHunt;
    endcase
  end

  assign CFG_DATA = r_cfg_data;
  assign CFG_ADDR = r_cfg_addr;
  assign CFG_WE   = r_we;
  assign DONE     = r_done;
  assign ERR      = r_err;

endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
- Serial configuration loader that programs the CLB array.
- Hunts a bit stream for a preamble, reads a frame count, then deserialises fixed-width configuration frames, one frame per CLB.
- Each frame is checked for parity and a stop bit, then presented as a parallel configuration word with a one-cycle write strobe and a CLB address.
- Sits between the device configuration pin and the per-CLB configuration registers.

Parameters:
- CFG_W, 37: configuration bits per CLB frame.
- ADDR_W, 6: width of the frame count and of CFG_ADDR; at most 2^ADDR_W-1 frames.
- PREAMBLE, 4'b0010: sync pattern, MSB received first.

Ports:
- K  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- DIN  input  1  serial configuration data, MSB first.
- DIN_EN  input  1  DIN is sampled only in cycles where DIN_EN=1; DIN_EN=0 stalls all progress.
- CFG_DATA  output  CFG_W  deserialised frame; held stable until the next CFG_WE.
- CFG_ADDR  output  ADDR_W  index of the frame on CFG_DATA, 0-based.
- CFG_WE  output  1  one-cycle write strobe for a good frame.
- DONE  output  1  high once all frames are loaded; sticky.
- ERR  output  1  high on a parity or stop-bit error; sticky.

Behaviour:
- Reset (async, RST_N=0):
  - State=HUNT; all shift registers and counters cleared.
  - CFG_DATA=0, CFG_ADDR=0, CFG_WE=0, DONE=0, ERR=0.
  - Reset in any state, including mid-frame, abandons the stream; reloading starts from the preamble.
- CFG_DATA field map, MSB to LSB:
  - [36:21] LUT mem[15:0]
  - [20:19] comboption
  - [18:13] o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1
  - [12:11] DQmux1, DQmux2
  - [10] floporlatch
  - [9:0] mux2select, mux3select, mux4select, mux5select, mux6select (2 bits each, mux2select in [9:8])
- "Bit" below means one cycle with DIN_EN=1.
- HUNT:
  - Shifts DIN into a 4-bit window.
  - When the window equals PREAMBLE after a bit, go to COUNT.
  - Overlapping matches are allowed; any leading bits before the preamble are ignored.
- COUNT:
  - Shifts ADDR_W bits, MSB first, into N.
  - If N==0, go directly to DONE_ST.
  - Otherwise go to DATA with the frame index at 0.
- DATA:
  - Shifts CFG_W bits, MSB first, into the frame shift register.
  - Then go to PAR.
- PAR: one bit, P. The frame is good only if P equals the XOR of the CFG_W data bits.
- STOP: one bit, which must be 1.
  - Good frame (stop=1 and parity ok):
    - On the next edge, CFG_DATA is loaded from the shift register, CFG_ADDR is set to the frame index, and CFG_WE=1 for exactly one cycle.
    - The frame index then increments.
    - If the incremented index equals N, go to DONE_ST; otherwise return to DATA.
  - Bad frame (stop=0 or parity mismatch): no CFG_WE is issued; go to ERR_ST.
- Latency: CFG_WE is asserted in the cycle after the edge that samples the stop bit, independent of the DIN_EN level in that cycle.
- DONE_ST:
  - DONE=1 held until reset.
  - DIN is ignored and CFG_DATA/CFG_ADDR hold their last values.
- ERR_ST:
  - ERR=1 held until reset; DONE stays 0.
  - DIN is ignored and no further CFG_WE is issued.
- Boundary cases:
  - DIN_EN deasserted mid-field: the bit counter and shift registers freeze, with no loss or duplication of bits.
  - CFG_WE never asserts in the same cycle as ERR rising.
  - A preamble pattern appearing inside COUNT/DATA is treated as data, never as resync.
  - The frame index never wraps, since N ≤ 2^ADDR_W-1.

Test Plan:
- Reset then stream 1111 0010, N=000001, frame 37'h0_22C0_E2A0, parity 0, stop 1, DIN_EN=1 throughout → exactly one CFG_WE with CFG_DATA=37'h0_22C0_E2A0 and CFG_ADDR=0; DONE=1 the cycle after; ERR=0.
- Same single frame with parity bit 1 → no CFG_WE; ERR=1 sticky; DONE=0; further DIN toggling causes no change.
- N=3 with three good frames 37'h1, 37'h2, 37'h1F_FFFF_FFFF (parity bits 1, 1, 1) → three CFG_WE pulses with CFG_ADDR 0, 1, 2 and matching CFG_DATA; DONE rises only after the third.
- First frame of the N=3 case with DIN_EN=0 for 5 cycles after every 7th bit → CFG_DATA identical to the ungated run; CFG_WE count and order unchanged.
- Stream 0010, N=000000 → DONE=1 with no CFG_WE; good frame with stop bit 0 → ERR=1 and no CFG_WE.
- Assert RST_N=0 mid-DATA of frame 1 (N=2), then release and send a full N=1 stream → all outputs return to 0; one CFG_WE with CFG_ADDR=0; DONE=1.
